// File: rtl/tt_sweep_checker.sv
// -----------------------------------------------------------------------------
// tt_sweep_checker
//
// Built-in exhaustive truth-table checker for an N_IN-input, single-output
// combinational block. Walks every input vector 0 .. 2^N_IN-1 in ascending
// order, holds each one for HOLD cycles, then samples the block's output and
// compares it with the corresponding bit of EXPECTED. Reports how many vectors
// mismatched and the index of the first one that did.
//
// Optional feature (compile-time macro TT_SWEEP_MISR_EN):
//   Adds a 16-bit MISR (poly 0x1021, seed 16'hFFFF) folding in every sampled
//   response, exposed on the signature port. Without the macro neither the
//   MISR logic nor the port exist.
//
// Parameters:
//   N_IN      number of inputs of the block under check (1..12)
//   HOLD      cycles each vector is held before sampling (>= 1)
//   EXPECTED  expected truth table, bit i = expected output for vector i
//
// Ports:
//   clk              rising-edge clock
//   rst_n            synchronous active-low reset
//   start            begin a sweep (honoured in IDLE or DONE only)
//   vec              stimulus to the block inputs (MSB = first input)
//   dut_y            output of the block under check
//   busy             sweep in progress
//   done             sweep complete, held until next start or reset
//   err_cnt          number of mismatching vectors (never wraps)
//   first_err_idx    index of the first mismatching vector
//   first_err_valid  at least one mismatch recorded
//   signature        MISR response signature (TT_SWEEP_MISR_EN only)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | driving vectors, sampling dut_y every HOLD cycles
// DONE  | sweep finished, results stable, waiting for restart
// -----------------------------------------------------------------------------
module tt_sweep_checker #(
  parameter int unsigned                 N_IN     = 4,
  parameter int unsigned                 HOLD     = 5,
  parameter logic [(1 << N_IN) - 1:0]    EXPECTED = 16'h6996
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_err_idx,
  output logic            first_err_valid
`ifdef TT_SWEEP_MISR_EN
  ,
  output logic [15:0]     signature
`endif
);

  // Hold counter needs at least one bit even when HOLD == 1.
  localparam int unsigned CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [N_IN-1:0]  VEC_LAST  = {N_IN{1'b1}};
  localparam logic [N_IN-1:0]  VEC_ONE   = N_IN'(1);
  localparam logic [N_IN:0]    ERR_ONE   = (N_IN + 1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_IN:0]     err_cnt_q, err_cnt_d;
  logic [N_IN-1:0]   first_err_idx_q, first_err_idx_d;
  logic              first_err_valid_q, first_err_valid_d;

  logic              sample;
  logic              mismatch;

  assign sample   = (state_q == RUN) && (cnt_q == HOLD_LAST);
  assign mismatch = dut_y ^ EXPECTED[vec_q];

  always_comb begin
    state_d           = state_q;
    vec_d             = vec_q;
    cnt_d             = cnt_q;
    err_cnt_d         = err_cnt_q;
    first_err_idx_d   = first_err_idx_q;
    first_err_valid_d = first_err_valid_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d           = RUN;
          vec_d             = '0;
          cnt_d             = '0;
          err_cnt_d         = '0;
          first_err_idx_d   = '0;
          first_err_valid_d = 1'b0;
        end
      end

      RUN: begin
        if (sample) begin
          if (mismatch) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
            if (!first_err_valid_q) begin
              first_err_idx_d   = vec_q;
              first_err_valid_d = 1'b1;
            end
          end
          cnt_d = '0;
          if (vec_q == VEC_LAST) begin
            state_d = DONE;
            vec_d   = '0;
          end else begin
            vec_d = vec_q + VEC_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      vec_q             <= '0;
      cnt_q             <= '0;
      err_cnt_q         <= '0;
      first_err_idx_q   <= '0;
      first_err_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      vec_q             <= vec_d;
      cnt_q             <= cnt_d;
      err_cnt_q         <= err_cnt_d;
      first_err_idx_q   <= first_err_idx_d;
      first_err_valid_q <= first_err_valid_d;
    end
  end

  // busy/done come straight from the state register, so dut_y never reaches
  // an output combinationally.
  assign vec             = vec_q;
  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign err_cnt         = err_cnt_q;
  assign first_err_idx   = first_err_idx_q;
  assign first_err_valid = first_err_valid_q;

`ifdef TT_SWEEP_MISR_EN
  logic [15:0] sig_q, sig_d;
  logic        sig_fb;

  assign sig_fb = sig_q[15] ^ dut_y;

  always_comb begin
    sig_d = sig_q;
    if ((state_q != RUN) && start) begin
      sig_d = 16'hFFFF;
    end else if (sample) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (sig_fb ? 16'h1021 : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= 16'hFFFF;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign signature = sig_q;
`endif

endmodule

// File: tb/tb_tt_sweep_checker.sv
module tb_tt_sweep_checker;

  localparam int HOLD_T = 5;
  localparam int NV     = 16;
  localparam logic [15:0] EXP_TT = 16'h6996;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  vec;
  logic        dut_y;
  logic        busy;
  logic        done;
  logic [4:0]  err_cnt;
  logic [3:0]  first_err_idx;
  logic        first_err_valid;
`ifdef TT_SWEEP_MISR_EN
  logic [15:0] signature;
  logic [15:0] sig2;
`endif

  // Small second instance: HOLD=1, N_IN=2, AND function.
  logic        start2;
  logic [1:0]  vec2;
  logic        dut2_y;
  logic        busy2;
  logic        done2;
  logic [2:0]  err_cnt2;
  logic [1:0]  first_err_idx2;
  logic        first_err_valid2;

  // Response table of the emulated combinational block: y = resp[vec].
  logic [15:0] resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dut_y  = resp[vec];
  assign dut2_y = vec2[1] & vec2[0];

  tt_sweep_checker #(.N_IN(4), .HOLD(HOLD_T), .EXPECTED(EXP_TT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .vec             (vec),
    .dut_y           (dut_y),
    .busy            (busy),
    .done            (done),
    .err_cnt         (err_cnt),
    .first_err_idx   (first_err_idx),
    .first_err_valid (first_err_valid)
`ifdef TT_SWEEP_MISR_EN
    ,
    .signature       (signature)
`endif
  );

  tt_sweep_checker #(.N_IN(2), .HOLD(1), .EXPECTED(4'b1000)) dut2 (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start2),
    .vec             (vec2),
    .dut_y           (dut2_y),
    .busy            (busy2),
    .done            (done2),
    .err_cnt         (err_cnt2),
    .first_err_idx   (first_err_idx2),
    .first_err_valid (first_err_valid2)
`ifdef TT_SWEEP_MISR_EN
    ,
    .signature       (sig2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: results of one sweep derived directly from the response table.
  task automatic model(input logic [15:0] r, output int e_cnt, output int e_idx,
                       output int e_valid, output logic [15:0] e_sig);
    logic [15:0] diff;
    logic        fb;
    diff    = r ^ EXP_TT;
    e_cnt   = $countones(diff);
    e_idx   = 0;
    e_valid = 0;
    for (int i = NV - 1; i >= 0; i--) begin
      if (diff[i]) begin
        e_idx   = i;
        e_valid = 1;
      end
    end
    e_sig = 16'hFFFF;
    for (int i = 0; i < NV; i++) begin
      fb    = e_sig[15] ^ r[i];
      e_sig = {e_sig[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
  endtask

  task automatic sweep(input string tag, input logic [15:0] r, input bit repulse);
    int          e_cnt, e_idx, e_valid;
    logic [15:0] e_sig;
    model(r, e_cnt, e_idx, e_valid, e_sig);
    resp = r;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".start_busy"}, 32'(busy), 1);
    chk({tag, ".start_done"}, 32'(done), 0);
    chk({tag, ".start_vec"}, 32'(vec), 0);
    chk({tag, ".start_err_cnt"}, 32'(err_cnt), 0);
    chk({tag, ".start_fev"}, 32'(first_err_valid), 0);
    for (int c = 1; c <= NV * HOLD_T; c++) begin
      if (repulse && c == 16) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (c < NV * HOLD_T && (c % HOLD_T) == 0)
        chk({tag, ".vec_walk"}, 32'(vec), 32'(c / HOLD_T));
      if (c == NV * HOLD_T - 1) begin
        chk({tag, ".pre_end_busy"}, 32'(busy), 1);
        chk({tag, ".pre_end_done"}, 32'(done), 0);
      end
    end
    chk({tag, ".end_done"}, 32'(done), 1);
    chk({tag, ".end_busy"}, 32'(busy), 0);
    chk({tag, ".end_vec"}, 32'(vec), 0);
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(e_cnt));
    chk({tag, ".first_err_idx"}, 32'(first_err_idx), 32'(e_idx));
    chk({tag, ".first_err_valid"}, 32'(first_err_valid), 32'(e_valid));
`ifdef TT_SWEEP_MISR_EN
    chk({tag, ".signature"}, 32'(signature), 32'(e_sig));
`endif
    repeat (3) @(negedge clk);
    chk({tag, ".done_held"}, 32'(done), 1);
    chk({tag, ".err_cnt_held"}, 32'(err_cnt), 32'(e_cnt));
  endtask

  logic [15:0] xor_tt;
  bit          saw_done;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    resp   = 16'h0000;
    for (int i = 0; i < NV; i++) xor_tt[i] = ^(4'(i));

    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.vec", 32'(vec), 0);
    chk("rst.err_cnt", 32'(err_cnt), 0);
    chk("rst.first_err_idx", 32'(first_err_idx), 0);
    chk("rst.first_err_valid", 32'(first_err_valid), 0);
`ifdef TT_SWEEP_MISR_EN
    chk("rst.signature", 32'(signature), 32'hFFFF);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Stimulus and scoreboard agree on the golden XOR table.
    chk("xor_table", 32'(xor_tt), 32'(EXP_TT));

    sweep("xor", xor_tt, 1'b0);
    sweep("fault_a", xor_tt ^ 16'h0400, 1'b0);
    sweep("stuck0", 16'h0000, 1'b0);
    sweep("stuck0_restart", 16'h0000, 1'b0);
    sweep("repulse", xor_tt, 1'b1);
    sweep("xor_again", xor_tt, 1'b0);
    sweep("fault_a_again", xor_tt ^ 16'h0400, 1'b0);
    sweep("stuck1", 16'hFFFF, 1'b0);
    for (int n = 0; n < 3; n++) sweep("random", 16'($urandom), 1'b0);

    // Abort mid-sweep: reset while vector 7 is driven.
    resp = xor_tt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7 * HOLD_T) @(negedge clk);
    chk("abort.vec7", 32'(vec), 7);
    resp  = 16'h0000;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort.busy", 32'(busy), 0);
    chk("abort.done", 32'(done), 0);
    chk("abort.vec", 32'(vec), 0);
    chk("abort.err_cnt", 32'(err_cnt), 0);
    chk("abort.first_err_idx", 32'(first_err_idx), 0);
    chk("abort.first_err_valid", 32'(first_err_valid), 0);
`ifdef TT_SWEEP_MISR_EN
    chk("abort.signature", 32'(signature), 32'hFFFF);
`endif
    saw_done = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort.stays_idle", 32'(saw_done), 0);
    sweep("after_abort", xor_tt, 1'b0);

    // HOLD=1, N_IN=2 instance.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("h1.start_busy", 32'(busy2), 1);
    chk("h1.start_vec", 32'(vec2), 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c < 4) begin
        chk("h1.vec_walk", 32'(vec2), 32'(c));
        chk("h1.not_done", 32'(done2), 0);
      end
    end
    chk("h1.done", 32'(done2), 1);
    chk("h1.busy", 32'(busy2), 0);
    chk("h1.err_cnt", 32'(err_cnt2), 0);
    chk("h1.first_err_valid", 32'(first_err_valid2), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
